// File: rtl/pass_checker_if.sv
// ============================================================================
// pass_checker_if : keypad, ROM and status signals of the password stage
// Revision        : 1.0
// ============================================================================
`default_nettype none

interface pass_checker_if;
   logic        idChecked;
   logic [2:0]  pass_Adrs;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_enter;
   logic        key_clear;
   logic [2:0]  rom_addr;
   logic [15:0] rom_data;
   logic        passOut;
   logic        granted;
   logic        denied;
   logic        locked;
   logic [2:0]  attempts;
   logic [2:0]  digit_cnt;

   // Environment side: ID manager, keypad and password ROM
   modport master (
      output idChecked, pass_Adrs, key_valid, key_code, key_enter, key_clear,
             rom_data,
      input  rom_addr, passOut, granted, denied, locked, attempts, digit_cnt
   );

   // Password checker side
   modport slave (
      input  idChecked, pass_Adrs, key_valid, key_code, key_enter, key_clear,
             rom_data,
      output rom_addr, passOut, granted, denied, locked, attempts, digit_cnt
   );
endinterface

`default_nettype wire

// File: rtl/pass_checker.sv
// ============================================================================
// pass_checker : fetches a stored 4-digit password, compares keypad entry,
//                counts wrong attempts and enforces a timed lockout.
//                Optional entry timeout under macro PASS_TIMEOUT_EN.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module pass_checker #(
   parameter int MAX_TRIES   = 3,
   parameter int ROM_LAT     = 2,
   parameter int LOCK_CYC    = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  wire logic          clk,
   input  wire logic          rst,
   pass_checker_if.slave      bus
);

   localparam int WAIT_W = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);
   localparam int LOCK_W = $clog2(LOCK_CYC + 1);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ROM_LAT);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYC - 1);
   localparam logic [2:0]        TRIES_MAX = 3'(MAX_TRIES);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_ENTRY    = 4'd2,
      S_COMPARE  = 4'd3,
      S_FAIL     = 4'd4,
      S_GRANT    = 4'd5,
      S_LOCK     = 4'd6,
      S_LOCK_END = 4'd7,
      S_ABORT    = 4'd8,
      S_DONE     = 4'd9
   } state_t;

   state_t            state_q,     state_d;
   logic [2:0]        rom_addr_q,  rom_addr_d;
   logic [15:0]       ref_q,       ref_d;
   logic [15:0]       entered_q,   entered_d;
   logic [2:0]        digit_cnt_q, digit_cnt_d;
   logic [2:0]        attempts_q,  attempts_d;
   logic [WAIT_W-1:0] wait_q,      wait_d;
   logic [LOCK_W-1:0] lock_q,      lock_d;

   logic       pass_out;
   logic       granted_out;
   logic       denied_out;
   logic       locked_out;
   logic [2:0] attempts_inc;

   assign attempts_inc = attempts_q + 3'd1;

`ifdef PASS_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              key_any;

   assign key_any = bus.key_valid | bus.key_enter | bus.key_clear;
`endif

   always_comb begin
      state_d     = state_q;
      rom_addr_d  = rom_addr_q;
      ref_d       = ref_q;
      entered_d   = entered_q;
      digit_cnt_d = digit_cnt_q;
      attempts_d  = attempts_q;
      wait_d      = wait_q;
      lock_d      = lock_q;
      pass_out    = 1'b0;
      granted_out = 1'b0;
      denied_out  = 1'b0;
      locked_out  = 1'b0;
`ifdef PASS_TIMEOUT_EN
      idle_d      = idle_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.idChecked) begin
               rom_addr_d = bus.pass_Adrs;
               wait_d     = '0;
               state_d    = S_FETCH;
            end
         end

         // ROM data becomes valid ROM_LAT cycles into this state
         S_FETCH: begin
            if (wait_q == WAIT_LAST) begin
               ref_d       = bus.rom_data;
               entered_d   = '0;
               digit_cnt_d = '0;
               state_d     = S_ENTRY;
`ifdef PASS_TIMEOUT_EN
               idle_d      = '0;
`endif
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         S_ENTRY: begin
            if (bus.key_clear) begin
               entered_d   = '0;
               digit_cnt_d = '0;
            end else if (bus.key_enter) begin
               state_d = (digit_cnt_q == 3'd4) ? S_COMPARE : S_FAIL;
            end else if (bus.key_valid && (digit_cnt_q < 3'd4)) begin
               entered_d   = {entered_q[11:0], bus.key_code};
               digit_cnt_d = digit_cnt_q + 3'd1;
            end
`ifdef PASS_TIMEOUT_EN
            if (key_any) begin
               idle_d = '0;
            end else if (idle_q == IDLE_LAST) begin
               state_d = S_ABORT;
            end else begin
               idle_d = idle_q + 1'b1;
            end
`endif
         end

         S_COMPARE: begin
            state_d = (entered_q == ref_q) ? S_GRANT : S_FAIL;
         end

         S_FAIL: begin
            attempts_d = attempts_inc;
            if (attempts_inc == TRIES_MAX) begin
               lock_d  = '0;
               state_d = S_LOCK;
            end else begin
               denied_out  = 1'b1;
               entered_d   = '0;
               digit_cnt_d = '0;
               state_d     = S_ENTRY;
`ifdef PASS_TIMEOUT_EN
               idle_d      = '0;
`endif
            end
         end

         S_GRANT: begin
            granted_out = 1'b1;
            pass_out    = 1'b1;
            attempts_d  = '0;
            state_d     = S_DONE;
         end

         S_LOCK: begin
            locked_out = 1'b1;
            if (lock_q == LOCK_LAST) begin
               state_d = S_LOCK_END;
            end else begin
               lock_d = lock_q + 1'b1;
            end
         end

         S_LOCK_END: begin
            pass_out   = 1'b1;
            attempts_d = '0;
            state_d    = S_DONE;
         end

`ifdef PASS_TIMEOUT_EN
         S_ABORT: begin
            pass_out   = 1'b1;
            attempts_d = '0;
            state_d    = S_DONE;
         end
`endif

         // Hold until the ID manager drops its level so it cannot retrigger
         S_DONE: begin
            if (!bus.idChecked) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         rom_addr_q  <= '0;
         ref_q       <= '0;
         entered_q   <= '0;
         digit_cnt_q <= '0;
         attempts_q  <= '0;
         wait_q      <= '0;
         lock_q      <= '0;
`ifdef PASS_TIMEOUT_EN
         idle_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rom_addr_q  <= rom_addr_d;
         ref_q       <= ref_d;
         entered_q   <= entered_d;
         digit_cnt_q <= digit_cnt_d;
         attempts_q  <= attempts_d;
         wait_q      <= wait_d;
         lock_q      <= lock_d;
`ifdef PASS_TIMEOUT_EN
         idle_q      <= idle_d;
`endif
      end
   end

   assign bus.rom_addr  = rom_addr_q;
   assign bus.passOut   = pass_out;
   assign bus.granted   = granted_out;
   assign bus.denied    = denied_out;
   assign bus.locked    = locked_out;
   assign bus.attempts  = attempts_q;
   assign bus.digit_cnt = digit_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pass_checker.sv
// ============================================================================
// tb_pass_checker : directed self-checking bench for pass_checker
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_pass_checker;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   pass_checker_if bus();

   pass_checker #(
      .MAX_TRIES   (3),
      .ROM_LAT     (2),
      .LOCK_CYC    (16),
      .TIMEOUT_CYC (1024)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Two-stage synchronous password ROM
   logic [15:0] rom_mem [8];
   logic [15:0] rom_p1;

   always @(posedge clk) begin
      rom_p1       <= rom_mem[bus.rom_addr];
      bus.rom_data <= rom_p1;
   end

   // Pulse counters and back-to-back pulse detector
   int   po_cnt  = 0;
   int   gr_cnt  = 0;
   int   dn_cnt  = 0;
   int   dbl_cnt = 0;
   logic po_prev = 1'b0;
   logic gr_prev = 1'b0;
   logic dn_prev = 1'b0;

   always @(negedge clk) begin
      if (bus.passOut === 1'b1) po_cnt++;
      if (bus.granted === 1'b1) gr_cnt++;
      if (bus.denied  === 1'b1) dn_cnt++;
      if ((po_prev && bus.passOut === 1'b1) || (gr_prev && bus.granted === 1'b1) ||
          (dn_prev && bus.denied === 1'b1))
         dbl_cnt++;
      po_prev = (bus.passOut === 1'b1);
      gr_prev = (bus.granted === 1'b1);
      dn_prev = (bus.denied  === 1'b1);
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] c);
      bus.key_code  = c;
      bus.key_valid = 1'b1;
      tick();
      bus.key_valid = 1'b0;
   endtask

   task automatic do_enter();
      bus.key_enter = 1'b1;
      tick();
      bus.key_enter = 1'b0;
   endtask

   task automatic do_clear();
      bus.key_clear = 1'b1;
      tick();
      bus.key_clear = 1'b0;
   endtask

   task automatic enter4(input logic [15:0] v);
      press(v[15:12]);
      press(v[11:8]);
      press(v[7:4]);
      press(v[3:0]);
   endtask

   task automatic start(input logic [2:0] a);
      bus.pass_Adrs = a;
      bus.idChecked = 1'b1;
      repeat (5) tick();
   endtask

   task automatic end_session();
      bus.idChecked = 1'b0;
      repeat (2) tick();
   endtask

   int po0;
   int dn0;
   int gr0;
   int n;
   int guard;

   initial begin
      for (int i = 0; i < 8; i++) rom_mem[i] = 16'h5A5A ^ 16'(i);
      rom_mem[3] = 16'h1234;
      rom_mem[5] = 16'hA0F9;

      bus.idChecked = 1'b0;
      bus.pass_Adrs = 3'd0;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'd0;
      bus.key_enter = 1'b0;
      bus.key_clear = 1'b0;

      // Reset state
      repeat (3) tick();
      chk("rst_passOut",   bus.passOut,   0);
      chk("rst_granted",   bus.granted,   0);
      chk("rst_denied",    bus.denied,    0);
      chk("rst_locked",    bus.locked,    0);
      chk("rst_attempts",  bus.attempts,  0);
      chk("rst_digit_cnt", bus.digit_cnt, 0);
      chk("rst_rom_addr",  bus.rom_addr,  0);
      rst = 1'b1;
      tick();

      // Correct entry
      start(3'd3);
      chk("t1_rom_addr", bus.rom_addr, 3);
      enter4(16'h1234);
      chk("t1_digits", bus.digit_cnt, 4);
      po0 = po_cnt;
      do_enter();
      chk("t1_cmp_granted", bus.granted, 0);
      chk("t1_cmp_passOut", bus.passOut, 0);
      tick();
      chk("t1_granted", bus.granted, 1);
      chk("t1_passOut", bus.passOut, 1);
      chk("t1_attempts", bus.attempts, 0);
      tick();
      chk("t1_granted_end", bus.granted, 0);
      chk("t1_passOut_end", bus.passOut, 0);
      repeat (6) tick();
      chk("t1_single_pulse", po_cnt - po0, 1);
      end_session();

      // Wrong then correct
      start(3'd3);
      enter4(16'h1235);
      do_enter();
      tick();
      chk("t2_denied", bus.denied, 1);
      tick();
      chk("t2_denied_end", bus.denied, 0);
      chk("t2_attempts", bus.attempts, 1);
      chk("t2_digits", bus.digit_cnt, 0);
      enter4(16'h1234);
      do_enter();
      tick();
      chk("t2_granted", bus.granted, 1);
      tick();
      chk("t2_attempts_clr", bus.attempts, 0);
      end_session();

      // Lockout after three wrong entries
      start(3'd3);
      gr0 = gr_cnt;
      for (int i = 0; i < 2; i++) begin
         enter4(16'h0000);
         do_enter();
         tick();
         chk("t3_denied", bus.denied, 1);
         tick();
         chk("t3_attempts", bus.attempts, i + 1);
      end
      enter4(16'h0000);
      do_enter();
      tick();
      chk("t3_no_denied", bus.denied, 0);
      tick();
      chk("t3_locked", bus.locked, 1);
      chk("t3_attempts_lock", bus.attempts, 3);
      n = 0;
      guard = 0;
      while (bus.locked === 1'b1 && guard < 40) begin
         n++;
         guard++;
         bus.key_clear = 1'b1;
         tick();
      end
      bus.key_clear = 1'b0;
      chk("t3_lock_cycles", n, 16);
      chk("t3_passOut", bus.passOut, 1);
      chk("t3_granted", bus.granted, 0);
      chk("t3_keys_ignored", bus.digit_cnt, 4);
      tick();
      chk("t3_attempts_clr", bus.attempts, 0);
      chk("t3_passOut_end", bus.passOut, 0);
      chk("t3_no_grant", gr_cnt - gr0, 0);
      end_session();

      // Clear discards partial entry
      start(3'd3);
      press(4'h9);
      press(4'h9);
      do_clear();
      chk("t4_clear_digits", bus.digit_cnt, 0);
      enter4(16'h1234);
      do_enter();
      tick();
      chk("t4_clear_granted", bus.granted, 1);
      end_session();

      // Fifth digit ignored
      start(3'd3);
      enter4(16'h1234);
      press(4'h5);
      chk("t4_ovf_digits", bus.digit_cnt, 4);
      do_enter();
      tick();
      chk("t4_ovf_granted", bus.granted, 1);
      end_session();

      // Short entry, then clear+enter together
      start(3'd3);
      press(4'h1);
      press(4'h2);
      do_enter();
      chk("t4_short_denied", bus.denied, 1);
      tick();
      chk("t4_short_attempts", bus.attempts, 1);
      chk("t4_short_digits", bus.digit_cnt, 0);
      enter4(16'h1234);
      dn0 = dn_cnt;
      po0 = po_cnt;
      bus.key_clear = 1'b1;
      bus.key_enter = 1'b1;
      tick();
      bus.key_clear = 1'b0;
      bus.key_enter = 1'b0;
      chk("t4_ce_digits", bus.digit_cnt, 0);
      repeat (3) tick();
      chk("t4_ce_attempts", bus.attempts, 1);
      chk("t4_ce_no_denied", dn_cnt - dn0, 0);
      chk("t4_ce_no_pass", po_cnt - po0, 0);
      enter4(16'h1234);
      do_enter();
      tick();
      chk("t4_ce_granted", bus.granted, 1);
      end_session();

      // Hex digits compared as-is
      start(3'd5);
      chk("t5_rom_addr", bus.rom_addr, 5);
      enter4(16'hA0F9);
      do_enter();
      tick();
      chk("t5_granted", bus.granted, 1);
      end_session();

      // Reset mid-entry, restart on held idChecked
      po0 = po_cnt;
      start(3'd3);
      press(4'h1);
      press(4'h2);
      chk("t6_digits", bus.digit_cnt, 2);
      rst = 1'b0;
      tick();
      chk("t6_rst_digits", bus.digit_cnt, 0);
      chk("t6_rst_rom_addr", bus.rom_addr, 0);
      chk("t6_rst_passOut", bus.passOut, 0);
      chk("t6_rst_locked", bus.locked, 0);
      rst = 1'b1;
      tick();
      chk("t6_refetch_addr", bus.rom_addr, 3);
      chk("t6_no_pass", po_cnt - po0, 0);
      repeat (4) tick();
      enter4(16'h1234);
      do_enter();
      tick();
      chk("t6_granted", bus.granted, 1);
      end_session();

      // Long idle in entry
      start(3'd3);
      press(4'h1);
      po0 = po_cnt;
      gr0 = gr_cnt;
      repeat (2000) tick();
`ifdef PASS_TIMEOUT_EN
      chk("t7_abort_pulse", po_cnt - po0, 1);
      chk("t7_abort_no_grant", gr_cnt - gr0, 0);
      chk("t7_abort_attempts", bus.attempts, 0);
`else
      chk("t7_no_pulse", po_cnt - po0, 0);
      chk("t7_digits_kept", bus.digit_cnt, 1);
      press(4'h2);
      press(4'h3);
      press(4'h4);
      do_enter();
      tick();
      chk("t7_granted", bus.granted, 1);
`endif
      end_session();

      chk("pulse_width", dbl_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
